// File: rtl/psram_pkg.sv
// Shared types and constants for the PSRAM capture sequencer.
package psram_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    POST  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } cap_state_t;

  localparam int BURST_BYTES  = 16;
  localparam int BURST_BEATS  = 8;
  localparam int PSRAM_ADDR_W = 25;

endpackage

// File: rtl/psram_capture_ctrl_if.sv
// Write-address / write-response channel between the capture sequencer and psram_ctrl.
interface psram_capture_ctrl_if #(
  parameter int ADDR_W = 25
);
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic              bvalid;

  modport master (output awaddr, output awvalid, input awready, input bvalid);
  modport slave  (input awaddr, input awvalid, output awready, output bvalid);
endinterface

// File: rtl/ring_addr_gen.sv
// Burst address pointer over a circular PSRAM region, with a sticky wrapped flag.
module ring_addr_gen
  import psram_pkg::*;
#(
  parameter int                ADDR_W     = PSRAM_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 25'h000_0000,
  parameter logic [ADDR_W-1:0] RING_BYTES = 25'h080_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              wrapped
);

  // One extra bit so the end-of-ring compare survives a ring ending at the top of memory.
  localparam logic [ADDR_W:0] RING_END = {1'b0, BASE_ADDR} + {1'b0, RING_BYTES};
  localparam logic [ADDR_W:0] STEP     = (ADDR_W + 1)'(BURST_BYTES);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wrapped_q, wrapped_d;
  logic [ADDR_W:0]   next_s;

  always_comb begin
    next_s    = {1'b0, addr_q} + STEP;
    addr_d    = addr_q;
    wrapped_d = wrapped_q;
    if (init) begin
      addr_d    = BASE_ADDR;
      wrapped_d = 1'b0;
    end else if (step) begin
      if (next_s == RING_END) begin
        addr_d    = BASE_ADDR;
        wrapped_d = 1'b1;
      end else begin
        addr_d    = next_s[ADDR_W-1:0];
        wrapped_d = wrapped_q;
      end
    end else begin
      addr_d    = addr_q;
      wrapped_d = wrapped_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q    <= BASE_ADDR;
      wrapped_q <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign addr    = addr_q;
  assign wrapped = wrapped_q;

endmodule

// File: rtl/psram_capture_ctrl.sv
// ADC capture sequencer: arm/trigger/post-trigger control issuing one 16-byte write burst at a time.
module psram_capture_ctrl
  import psram_pkg::*;
#(
  parameter int                ADDR_W      = PSRAM_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 25'h000_0000,
  parameter logic [ADDR_W-1:0] RING_BYTES  = 25'h080_0000,
  parameter logic [15:0]       POST_BURSTS = 16'd1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  arm,
  input  logic                  trigger,
  input  logic                  abort,
  input  logic                  psram_ready,
  input  logic                  fifo_almost_empty,
  psram_capture_ctrl_if.master  aw,
  output logic [ADDR_W-1:0]     trig_addr,
  output logic                  wrapped,
  output logic                  busy,
  output logic                  done
);

  cap_state_t        state_q, state_d;
  logic [15:0]       post_cnt_q, post_cnt_d;
  logic              outst_q, outst_d;
  logic              awvalid_q, awvalid_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              init_s, issue_s, issue_ok_s, hs_s;
  logic [ADDR_W-1:0] addr_s;

  ring_addr_gen #(
    .ADDR_W     (ADDR_W),
    .BASE_ADDR  (BASE_ADDR),
    .RING_BYTES (RING_BYTES)
  ) u_ring (
    .clk     (clk),
    .reset   (reset),
    .init    (init_s),
    .step    (hs_s),
    .addr    (addr_s),
    .wrapped (wrapped)
  );

  assign hs_s       = awvalid_q & aw.awready;
  // Single burst in flight: the FIFO level lags a cycle behind each accepted burst.
  assign issue_ok_s = psram_ready & ~fifo_almost_empty & ~awvalid_q & ~outst_q;

  always_comb begin
    state_d     = state_q;
    post_cnt_d  = post_cnt_q;
    trig_addr_d = trig_addr_q;
    init_s      = 1'b0;
    issue_s     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (arm) begin
          state_d    = ARMED;
          init_s     = 1'b1;
          post_cnt_d = 16'd0;
        end else begin
          state_d = state_q;
        end
      end
      ARMED: begin
        if (abort) begin
          state_d = DRAIN;
        end else begin
          issue_s = issue_ok_s;
          if (trigger) begin
            state_d     = POST;
            trig_addr_d = addr_s;
          end else begin
            state_d = ARMED;
          end
        end
      end
      POST: begin
        if (hs_s && (post_cnt_q < POST_BURSTS)) begin
          post_cnt_d = post_cnt_q + 16'd1;
        end else begin
          post_cnt_d = post_cnt_q;
        end
        if (abort) begin
          state_d = DRAIN;
        end else if (post_cnt_q < POST_BURSTS) begin
          issue_s = issue_ok_s;
        end else if (!outst_q && !awvalid_q) begin
          state_d = DONE;
        end else begin
          state_d = POST;
        end
      end
      DRAIN: begin
        if (!awvalid_q && !outst_q) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (hs_s) begin
      awvalid_d = 1'b0;
    end else if (issue_s) begin
      awvalid_d = 1'b1;
    end else begin
      awvalid_d = awvalid_q;
    end

    if (hs_s) begin
      outst_d = 1'b1;
    end else if (aw.bvalid) begin
      outst_d = 1'b0;
    end else begin
      outst_d = outst_q;
    end

    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      post_cnt_q  <= 16'd0;
      outst_q     <= 1'b0;
      awvalid_q   <= 1'b0;
      trig_addr_q <= {ADDR_W{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      post_cnt_q  <= post_cnt_d;
      outst_q     <= outst_d;
      awvalid_q   <= awvalid_d;
      trig_addr_q <= trig_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign aw.awaddr  = addr_s;
  assign aw.awvalid = awvalid_q;
  assign trig_addr  = trig_addr_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_psram_capture_ctrl.sv
// Bench for psram_capture_ctrl: directed capture scenarios, an issue-rule table and a randomized run against a reference model.
module tb_psram_capture_ctrl;

  localparam int              AW    = 25;
  localparam logic [AW-1:0]   BASE  = 25'h000_0000;
  localparam logic [AW-1:0]   RING  = 25'h000_0040;
  localparam logic [15:0]     POSTB = 16'd3;
  localparam int              NB    = 4;
  localparam int PH_IDLE = 0, PH_ARMED = 1, PH_POST = 2, PH_DRAIN = 3, PH_DONE = 4;

  typedef struct {
    logic rdy;
    logic fae;
    logic exp_awv;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset, arm, trigger, abort, psram_ready, fifo_almost_empty;
  logic [AW-1:0] trig_addr;
  logic          wrapped, busy, done;
  int            checks = 0;
  int            errors = 0;

  bit hold_ready = 1'b0, rand_mode = 1'b0, hs_flag = 1'b0, m_valid = 1'b0;
  int aw_delay = 0, b_delay = 0, aw_cnt = 0, cur_delay = 0, b_cnt = 0, b_count = 0;
  logic [AW-1:0] hs_q[$];
  bit            hs_wrap_q[$];
  int            m_phase = PH_IDLE, m_hs = 0, m_post = 0;
  bit            m_awv = 1'b0, m_out = 1'b0;
  logic [AW-1:0] m_trig = '0;

  psram_capture_ctrl_if #(.ADDR_W(AW)) aw_if ();

  psram_capture_ctrl #(
    .ADDR_W      (AW),
    .BASE_ADDR   (BASE),
    .RING_BYTES  (RING),
    .POST_BURSTS (POSTB)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .arm               (arm),
    .trigger           (trigger),
    .abort             (abort),
    .psram_ready       (psram_ready),
    .fifo_almost_empty (fifo_almost_empty),
    .aw                (aw_if),
    .trig_addr         (trig_addr),
    .wrapped           (wrapped),
    .busy              (busy),
    .done              (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] exp_addr(input int n);
    return BASE + AW'((n % NB) * 16);
  endfunction

  task automatic wait_awaddr(input logic [AW-1:0] a, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      tick();
      if (aw_if.awvalid && aw_if.awaddr == a) ok = 1'b1;
    end
  endtask

  task automatic wait_busy_low(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      tick();
      if (!busy) ok = 1'b1;
    end
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      tick();
      if (done) ok = 1'b1;
    end
  endtask

  task automatic wait_hs(input int n, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      tick();
      if (hs_q.size() >= n) ok = 1'b1;
    end
  endtask

  task automatic count_awvalid(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (aw_if.awvalid) cnt++;
    end
  endtask

  // AW/B responder plus cycle-level reference model, evaluated between clock edges.
  initial begin
    bit hs, hs_m, may_issue, rearm, n_awv, n_out;
    int nph;
    logic [53:0] act_v, exp_v;
    aw_if.awready = 1'b0;
    aw_if.bvalid  = 1'b0;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        exp_v = {m_awv, exp_addr(m_hs), (m_hs >= NB),
                 (m_phase == PH_ARMED || m_phase == PH_POST || m_phase == PH_DRAIN),
                 (m_phase == PH_DONE), m_trig};
        act_v = {aw_if.awvalid, aw_if.awaddr, wrapped, busy, done, trig_addr};
        check("model{awvalid,awaddr,wrapped,busy,done,trig_addr}", 64'(act_v), 64'(exp_v));
      end

      aw_if.bvalid = 1'b0;
      if (hs_flag) begin
        hs_flag = 1'b0;
        b_cnt   = (rand_mode ? int'($urandom_range(0, 3)) : b_delay) + 1;
      end
      if (b_cnt > 0) begin
        b_cnt--;
        if (b_cnt == 0) begin
          aw_if.bvalid = 1'b1;
          b_count++;
        end
      end
      if (aw_if.awvalid && !hold_ready) begin
        if (aw_cnt >= cur_delay) aw_if.awready = 1'b1;
        else begin
          aw_if.awready = 1'b0;
          aw_cnt++;
        end
      end else begin
        aw_if.awready = 1'b0;
        if (!aw_if.awvalid) begin
          aw_cnt    = 0;
          cur_delay = rand_mode ? int'($urandom_range(0, 4)) : aw_delay;
        end
      end
      hs = aw_if.awvalid && aw_if.awready && !reset;
      if (hs) begin
        hs_flag = 1'b1;
        hs_q.push_back(aw_if.awaddr);
        hs_wrap_q.push_back(wrapped);
      end

      if (reset) begin
        m_phase = PH_IDLE; m_hs = 0; m_post = 0;
        m_awv = 1'b0; m_out = 1'b0; m_trig = '0; m_valid = 1'b1;
      end else begin
        hs_m = m_awv && aw_if.awready;
        may_issue = 1'b0;
        rearm = 1'b0;
        nph = m_phase;
        case (m_phase)
          PH_IDLE, PH_DONE: if (arm) begin nph = PH_ARMED; rearm = 1'b1; end
          PH_ARMED: begin
            if (abort) nph = PH_DRAIN;
            else begin
              may_issue = 1'b1;
              if (trigger) begin nph = PH_POST; m_trig = exp_addr(m_hs); end
            end
          end
          PH_POST: begin
            if (abort) nph = PH_DRAIN;
            else if (m_post < int'(POSTB)) may_issue = 1'b1;
            else if (!m_out && !m_awv) nph = PH_DONE;
          end
          PH_DRAIN: if (!m_awv && !m_out) nph = PH_IDLE;
          default: nph = PH_IDLE;
        endcase
        if (hs_m && m_phase == PH_POST && m_post < int'(POSTB)) m_post++;
        n_awv = hs_m ? 1'b0 :
                ((may_issue && psram_ready && !fifo_almost_empty && !m_awv && !m_out) ? 1'b1 : m_awv);
        n_out = hs_m ? 1'b1 : (aw_if.bvalid ? 1'b0 : m_out);
        if (hs_m) m_hs++;
        if (rearm) begin m_hs = 0; m_post = 0; end
        m_awv = n_awv;
        m_out = n_out;
        m_phase = nph;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, errors so far %0d", errors);
    $fatal(1, "time limit");
  end

  initial begin
    vec_t vecs[6];
    logic [AW-1:0] exp_ring[5];
    bit ok;
    int cnt, n0;
    vecs[0] = '{rdy: 1'b1, fae: 1'b0, exp_awv: 1'b1};
    vecs[1] = '{rdy: 1'b0, fae: 1'b0, exp_awv: 1'b0};
    vecs[2] = '{rdy: 1'b1, fae: 1'b1, exp_awv: 1'b0};
    vecs[3] = '{rdy: 1'b0, fae: 1'b1, exp_awv: 1'b0};
    vecs[4] = '{rdy: 1'b1, fae: 1'b0, exp_awv: 1'b1};
    vecs[5] = '{rdy: 1'b0, fae: 1'b0, exp_awv: 1'b0};
    exp_ring = '{25'h00, 25'h10, 25'h20, 25'h30, 25'h00};

    reset = 1'b1; arm = 1'b0; trigger = 1'b0; abort = 1'b0;
    psram_ready = 1'b0; fifo_almost_empty = 1'b1;
    aw_delay = 3; b_delay = 2;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_awvalid", 64'(aw_if.awvalid), 64'd0);
    check("rst_awaddr", 64'(aw_if.awaddr), 64'(BASE));
    check("rst_trig_addr", 64'(trig_addr), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_wrapped", 64'(wrapped), 64'd0);

    // first request latency and AXI hold while awready is late
    psram_ready = 1'b1; fifo_almost_empty = 1'b0; arm = 1'b1;
    tick();
    arm = 1'b0;
    check("arm_busy", 64'(busy), 64'd1);
    check("arm_awvalid", 64'(aw_if.awvalid), 64'd0);
    tick();
    check("first_awvalid", 64'(aw_if.awvalid), 64'd1);
    check("first_awaddr", 64'(aw_if.awaddr), 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_awvalid", 64'(aw_if.awvalid), 64'd1);
      check("hold_awaddr", 64'(aw_if.awaddr), 64'h0);
    end
    aw_delay = 0;
    wait_awaddr(25'h10, 50, ok);
    check("second_req_seen", 64'(ok), 64'd1);
    check("bvalid_before_second", 64'(b_count), 64'd1);

    wait_hs(5, 100, ok);
    check("five_hs_seen", 64'(ok), 64'd1);
    if (hs_q.size() >= 5) begin
      for (int i = 0; i < 5; i++) check("ring_addr", 64'(hs_q[i]), 64'(exp_ring[i]));
      check("wrapped_before_4th", 64'(hs_wrap_q[3]), 64'd0);
      check("wrapped_after_4th", 64'(hs_wrap_q[4]), 64'd1);
    end

    // trigger and abort together: abort wins, trig_addr untouched
    trigger = 1'b1; abort = 1'b1;
    tick();
    trigger = 1'b0; abort = 1'b0;
    check("trig_abort_trig_addr", 64'(trig_addr), 64'd0);
    check("trig_abort_busy", 64'(busy), 64'd1);
    wait_busy_low(50, ok);
    check("trig_abort_idle", 64'(ok), 64'd1);
    check("trig_abort_done", 64'(done), 64'd0);

    // trigger at 0x30, then exactly POST_BURSTS more bursts
    arm = 1'b1;
    tick();
    arm = 1'b0;
    wait_awaddr(25'h30, 100, ok);
    check("reach_0x30", 64'(ok), 64'd1);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    n0 = hs_q.size();
    check("trig_addr_0x30", 64'(trig_addr), 64'h30);
    wait_done(200, ok);
    check("post_done_seen", 64'(ok), 64'd1);
    check("post_hs_count", 64'(hs_q.size() - n0), 64'd3);
    if (hs_q.size() >= n0 + 3) begin
      for (int i = 0; i < 3; i++) check("post_addr", 64'(hs_q[n0 + i]), 64'(16 * i));
    end
    count_awvalid(20, cnt);
    check("done_no_awvalid", 64'(cnt), 64'd0);
    check("done_busy", 64'(busy), 64'd0);

    // re-arm from DONE restarts the ring
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("rearm_busy", 64'(busy), 64'd1);
    check("rearm_done", 64'(done), 64'd0);
    check("rearm_awaddr", 64'(aw_if.awaddr), 64'(BASE));
    check("rearm_wrapped", 64'(wrapped), 64'd0);

    // abort with a request stalled on awready
    hold_ready = 1'b1;
    wait_awaddr(25'h00, 50, ok);
    check("abort_req_seen", 64'(ok), 64'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("abort_hold_awvalid", 64'(aw_if.awvalid), 64'd1);
      check("abort_hold_awaddr", 64'(aw_if.awaddr), 64'h0);
      check("abort_hold_busy", 64'(busy), 64'd1);
      tick();
    end
    hold_ready = 1'b0;
    wait_busy_low(50, ok);
    check("abort_idle", 64'(ok), 64'd1);
    count_awvalid(20, cnt);
    check("abort_no_new_req", 64'(cnt), 64'd0);

    // FIFO and PSRAM-not-ready stalls
    fifo_almost_empty = 1'b1; arm = 1'b1;
    tick();
    arm = 1'b0;
    count_awvalid(100, cnt);
    check("fifo_stall", 64'(cnt), 64'd0);
    fifo_almost_empty = 1'b0;
    tick();
    check("fifo_release", 64'(aw_if.awvalid), 64'd1);
    psram_ready = 1'b0;
    repeat (10) tick();
    count_awvalid(100, cnt);
    check("ready_stall", 64'(cnt), 64'd0);
    psram_ready = 1'b1;
    tick();
    check("ready_release", 64'(aw_if.awvalid), 64'd1);

    // issue-rule table from a quiet ARMED state
    for (int v = 0; v < 6; v++) begin
      psram_ready = 1'b1; fifo_almost_empty = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
        tick();
        if (!aw_if.awvalid && !m_out) ok = 1'b1;
      end
      check("vec_quiesce", 64'(ok), 64'd1);
      psram_ready = vecs[v].rdy; fifo_almost_empty = vecs[v].fae;
      tick();
      check($sformatf("vec%0d_awvalid", v), 64'(aw_if.awvalid), 64'(vecs[v].exp_awv));
    end
    psram_ready = 1'b1; fifo_almost_empty = 1'b1;

    // randomized run, checked every cycle by the model
    rand_mode = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      psram_ready       = ($urandom_range(0, 7) != 0);
      fifo_almost_empty = ($urandom_range(0, 3) == 0);
      arm               = ($urandom_range(0, 39) == 0);
      trigger           = ($urandom_range(0, 29) == 0);
      abort             = ($urandom_range(0, 79) == 0);
      tick();
    end
    arm = 1'b0; trigger = 1'b0; abort = 1'b0;
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/psram_capture_ctrl.md
Name: psram_capture_ctrl

Overview:
- Sequences ADC capture into PSRAM: watches the 16-bit ADC write-FIFO level and issues 8-beat (16-byte) write-burst address requests to psram_ctrl.
- Runs a circular buffer over a PSRAM region, with arm/trigger/post-trigger semantics and trigger-address capture.
- Replaces the free-running awvalid toggle in blaster_chip. Sits between adc_mem_fifo (almost_empty) and the psram_ctrl AW/B channels.

Parameters:
- ADDR_W, 25, PSRAM byte-address width.
- BASE_ADDR, 25'h000_0000, first byte of the capture ring; must be 16-byte aligned.
- RING_BYTES, 25'h080_0000, ring size in bytes; a multiple of 16 and at least 32.
- POST_BURSTS, 16'd1024, bursts written after the trigger before the capture completes; at least 1.

Ports:
- clk  in  1  48 MHz system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- arm  in  1  single-cycle pulse; starts a new capture from IDLE or DONE.
- trigger  in  1  single-cycle pulse; marks the trigger point while ARMED.
- abort  in  1  single-cycle pulse; cancels any capture in progress.
- psram_ready  in  1  psram_ctrl is initialised and accepting requests.
- fifo_almost_empty  in  1  write FIFO holds fewer than 8 words.
- awaddr  out  ADDR_W  write burst byte address.
- awvalid  out  1  write address valid.
- awready  in  1  write address accepted.
- bvalid  in  1  write burst complete, one pulse per burst (bready is tied 1 externally).
- trig_addr  out  ADDR_W  awaddr value latched in the trigger cycle.
- wrapped  out  1  ring has wrapped at least once since arm, so pre-trigger data fills the whole ring.
- busy  out  1  high whenever the state is not IDLE and not DONE.
- done  out  1  high while in DONE.

Behaviour:
- Reset values:
  - state IDLE; awaddr BASE_ADDR.
  - awvalid, trig_addr, wrapped, done, busy all 0.
  - post counter 0; outstanding flag 0.
- States: IDLE, ARMED, POST, DRAIN, DONE.
  - IDLE: on arm → ARMED. awaddr ← BASE_ADDR, wrapped ← 0, post counter ← 0.
  - ARMED: issues bursts continuously. On trigger → POST; trig_addr ← current awaddr, taken before any same-cycle increment.
  - POST: issues bursts. Each AW handshake increments the post counter. When the counter reaches POST_BURSTS, stop issuing; enter DONE once the outstanding flag is 0.
  - DONE: done = 1. On arm → ARMED with the same initialisation as IDLE.
  - abort in ARMED or POST → DRAIN. In DRAIN no new requests are issued. Return to IDLE when awvalid = 0 and outstanding = 0. abort in IDLE, DONE or DRAIN is ignored.
- Issue rule, evaluated in ARMED, or in POST while the counter is below POST_BURSTS. Assert awvalid on the next cycle when all of the following hold:
  - psram_ready = 1;
  - fifo_almost_empty = 0;
  - awvalid = 0;
  - outstanding = 0.
- At most one burst is in flight; this prevents double-issue against a FIFO level that lags by one cycle.
- AXI rule: once awvalid is asserted, awvalid and awaddr hold stable until awready. This applies in every state, including DRAIN and after abort.
- On a handshake (awvalid & awready):
  - awvalid ← 0; outstanding ← 1.
  - awaddr ← awaddr + 16. If the result equals BASE_ADDR + RING_BYTES, awaddr ← BASE_ADDR instead and wrapped ← 1.
- bvalid clears outstanding. If bvalid and a handshake occur in the same cycle, outstanding stays 1.
- A handshake in the trigger cycle counts as pre-trigger and does not increment the post counter.
- Pulses ignored outside their states: trigger outside ARMED, and arm in ARMED, POST or DRAIN.
- If trigger and abort arrive in the same cycle, abort wins: the state goes to DRAIN and trig_addr is unchanged.
- When psram_ready drops mid-capture, no new issue starts; an asserted awvalid still holds until awready.
- Address arithmetic: ADDR_W-bit unsigned. BASE_ADDR + RING_BYTES is computed at ADDR_W + 1 bits, so the wrap compare is correct at the top of the address space.
- Post counter is 16 bits and saturates at POST_BURSTS.
- Latency: from fifo_almost_empty falling (with all other issue conditions met) to awvalid high is 1 cycle.

Decomposition:
- Package psram_pkg:
  - typedef cap_state_t enum {IDLE, ARMED, POST, DRAIN, DONE};
  - localparam BURST_BYTES = 16;
  - localparam BURST_BEATS = 8;
  - localparam PSRAM_ADDR_W = 25.
- One sub-module, ring_addr_gen: holds awaddr, provides the increment-by-BURST_BYTES and wrap logic, and outputs the wrapped flag. Ports: clk, reset, init, step, addr, wrapped.
- The FSM, issue logic and outstanding tracking stay in psram_capture_ctrl.

Test Plan:
- Reset, then pulse arm with fifo_almost_empty = 0, psram_ready = 1 and awready after 3 cycles → awvalid rises 1 cycle after ARMED is entered; awaddr = 0x0000000 is stable until awready; the next request is at 0x0000010 only after bvalid.
- Use RING_BYTES = 64 and run 5 bursts → addresses are 0x00, 0x10, 0x20, 0x30, 0x00; wrapped goes to 1 on the 4th handshake.
- trigger when awaddr = 0x30 with POST_BURSTS = 3 → trig_addr = 0x30; exactly 3 further handshakes occur; done rises after the 3rd bvalid; no further awvalid.
- abort while awvalid is asserted and awready is held off for 5 cycles → awvalid and awaddr stay stable; after the handshake and bvalid the state reaches IDLE; busy = 0 and no new requests follow.
- Hold fifo_almost_empty = 1, or psram_ready = 0, in ARMED for 100 cycles → awvalid stays 0. Release it → awvalid appears on the next cycle.
- Pulse trigger and abort in the same cycle → trig_addr is unchanged (0). In DONE, arm restarts at BASE_ADDR with wrapped = 0.
